// File: rtl/regfile_param.sv
// regfile_param: parameterised register file with two combinational read
// ports, two compare temp registers (t0/t1) feeding a registered equality
// flag, and a saturating stack pointer that lives in register SP_IDX.
//
// Optional feature: define REGFILE_BYPASS_EN to forward wdata to a read
// port in the same cycle as a write to the address that port is reading.
// Bypass applies only to the general registers. It does not apply in
// compare mode, to the temp registers, or to the stack-pointer push/pop path.
module regfile_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2,
    parameter int SP_IDX = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              tmp_we,
    input  logic              tmp_sel,
    input  logic              cmp_mode,
    input  logic              sp_push,
    input  logic              sp_pop,
    output logic              eq,
    output logic              sp_err
);

    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] SP_ADDR = ADDR_W'(SP_IDX);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] t0;
    logic [DATA_W-1:0] t1;
    logic [DATA_W-1:0] t0_next;
    logic [DATA_W-1:0] t1_next;

    logic [DATA_W-1:0] sp_cur;
    logic [DATA_W-1:0] sp_next;
    logic              sp_update;
    logic              sp_fault;
    logic              write_hits_sp;
    logic              push_only;
    logic              pop_only;

    assign sp_cur        = regs[SP_ADDR];
    assign write_hits_sp = we && (waddr == SP_ADDR);
    assign push_only     = sp_push && !sp_pop;
    assign pop_only      = sp_pop && !sp_push;

    // Stack-pointer step: saturate at both ends, and let a direct write to SP win over push/pop
    always_comb begin
        sp_next   = sp_cur;
        sp_update = 1'b0;
        sp_fault  = 1'b0;
        if (!write_hits_sp) begin
            if (push_only) begin
                if (sp_cur == '0) begin
                    sp_fault = 1'b1;
                end else begin
                    sp_next   = sp_cur - DATA_W'(1);
                    sp_update = 1'b1;
                end
            end else if (pop_only) begin
                if (sp_cur == '1) begin
                    sp_fault = 1'b1;
                end else begin
                    sp_next   = sp_cur + DATA_W'(1);
                    sp_update = 1'b1;
                end
            end
        end
    end

    // Next-state of the compare temps, shared by the temp registers and the eq flag
    always_comb begin
        t0_next = t0;
        t1_next = t1;
        if (tmp_we) begin
            if (tmp_sel) begin
                t1_next = wdata;
            end else begin
                t0_next = wdata;
            end
        end
    end

    // General registers: reset image, then write port, then stack-pointer step
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (i == SP_IDX) begin
                    regs[i] <= '1;
                end else begin
                    regs[i] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (we && (waddr == ADDR_W'(i))) begin
                    regs[i] <= wdata;
                end else if ((i == SP_IDX) && sp_update) begin
                    regs[i] <= sp_next;
                end
            end
        end
    end

    // Temp registers and the registered equality flag derived from their next state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            t0 <= '0;
            t1 <= '0;
            eq <= 1'b1;
        end else begin
            t0 <= t0_next;
            t1 <= t1_next;
            eq <= (t0_next == t1_next);
        end
    end

    // Sticky stack fault flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sp_err <= 1'b0;
        end else if (sp_fault) begin
            sp_err <= 1'b1;
        end
    end

    // Read port A: temp t0 in compare mode, otherwise the addressed register
    always_comb begin
        rdata_a = regs[raddr_a];
        if (cmp_mode) begin
            rdata_a = t0;
        end
`ifdef REGFILE_BYPASS_EN
        else if (we && (waddr == raddr_a)) begin
            rdata_a = wdata;
        end
`endif
    end

    // Read port B: temp t1 in compare mode, otherwise the addressed register
    always_comb begin
        rdata_b = regs[raddr_b];
        if (cmp_mode) begin
            rdata_b = t1;
        end
`ifdef REGFILE_BYPASS_EN
        else if (we && (waddr == raddr_b)) begin
            rdata_b = wdata;
        end
`endif
    end

endmodule

// File: tb/tb_regfile_param.sv
// Directed testbench for regfile_param at DATA_W=8, ADDR_W=2, SP_IDX=2.
module tb_regfile_param;

    logic       clk;
    logic       rst_n;
    logic       we;
    logic [1:0] waddr;
    logic [7:0] wdata;
    logic [1:0] raddr_a;
    logic [1:0] raddr_b;
    logic [7:0] rdata_a;
    logic [7:0] rdata_b;
    logic       tmp_we;
    logic       tmp_sel;
    logic       cmp_mode;
    logic       sp_push;
    logic       sp_pop;
    logic       eq;
    logic       sp_err;

    int compared   = 0;
    int mismatched = 0;

    regfile_param #(.DATA_W(8), .ADDR_W(2), .SP_IDX(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .raddr_a  (raddr_a),
        .raddr_b  (raddr_b),
        .rdata_a  (rdata_a),
        .rdata_b  (rdata_b),
        .tmp_we   (tmp_we),
        .tmp_sel  (tmp_sel),
        .cmp_mode (cmp_mode),
        .sp_push  (sp_push),
        .sp_pop   (sp_pop),
        .eq       (eq),
        .sp_err   (sp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Return every control input to idle
    task automatic applyStimulus();
        rst_n    = 1'b1;
        we       = 1'b0;
        waddr    = 2'd0;
        wdata    = 8'h00;
        tmp_we   = 1'b0;
        tmp_sel  = 1'b0;
        cmp_mode = 1'b0;
        sp_push  = 1'b0;
        sp_pop   = 1'b0;
    endtask

    // Advance one clock and settle just after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare one observed value against its expected value
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Read register addr through port A after settling
    task automatic readA(input logic [1:0] addr);
        raddr_a = addr;
        #1;
    endtask

    // Pulse reset for one edge
    task automatic doReset();
        applyStimulus();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    logic [7:0] same_cycle_exp;

    initial begin
        applyStimulus();
        raddr_a = 2'd0;
        raddr_b = 2'd0;

        // Reset image
        doReset();
        raddr_a = 2'd0; raddr_b = 2'd1; #1;
        checkOutput("rst_reg0", rdata_a, 8'h00);
        checkOutput("rst_reg1", rdata_b, 8'h00);
        raddr_a = 2'd2; raddr_b = 2'd3; #1;
        checkOutput("rst_reg2_sp", rdata_a, 8'hFF);
        checkOutput("rst_reg3", rdata_b, 8'h00);
        checkOutput("rst_eq", eq, 1'b1);
        checkOutput("rst_sp_err", sp_err, 1'b0);

        // Write 0x5A, then overwrite with 0x00 and observe same-cycle read
        we = 1'b1; waddr = 2'd1; wdata = 8'h5A;
        tick();
        raddr_b = 2'd1;
        #1;
        checkOutput("wr_5a", rdata_b, 8'h5A);
        wdata = 8'h00;
        #1;
`ifdef REGFILE_BYPASS_EN
        same_cycle_exp = 8'h00;
`else
        same_cycle_exp = 8'h5A;
`endif
        checkOutput("wr_same_cycle", rdata_b, same_cycle_exp);
        tick();
        we = 1'b0;
        #1;
        checkOutput("wr_zero_next", rdata_b, 8'h00);

        // Two more registers, read on both ports at once
        we = 1'b1; waddr = 2'd3; wdata = 8'hA5;
        tick();
        waddr = 2'd0; wdata = 8'h3C;
        tick();
        we = 1'b0;
        raddr_a = 2'd0; raddr_b = 2'd3; #1;
        checkOutput("rd_a_reg0", rdata_a, 8'h3C);
        checkOutput("rd_b_reg3", rdata_b, 8'hA5);

        // Compare temps and eq latency
        tmp_we = 1'b1; tmp_sel = 1'b0; wdata = 8'h40;
        tick();
        checkOutput("eq_after_t0", eq, 1'b0);
        tmp_sel = 1'b1; wdata = 8'h40;
        tick();
        checkOutput("eq_t0_t1_match", eq, 1'b1);
        wdata = 8'h41;
        tick();
        tmp_we = 1'b0;
        checkOutput("eq_t1_differs", eq, 1'b0);
        cmp_mode = 1'b1; raddr_a = 2'd0; raddr_b = 2'd3; #1;
        checkOutput("cmp_rdata_a_t0", rdata_a, 8'h40);
        checkOutput("cmp_rdata_b_t1", rdata_b, 8'h41);
        cmp_mode = 1'b0; #1;
        checkOutput("cmp_off_reg0", rdata_a, 8'h3C);

        // Reset with a write and a pop pending: both discarded
        applyStimulus();
        rst_n = 1'b0; we = 1'b1; waddr = 2'd1; wdata = 8'h99; sp_pop = 1'b1;
        tick();
        applyStimulus();
        raddr_a = 2'd1; raddr_b = 2'd2; #1;
        checkOutput("rst_drops_write", rdata_a, 8'h00);
        checkOutput("rst_drops_pop", rdata_b, 8'hFF);
        checkOutput("rst_eq_restored", eq, 1'b1);
        checkOutput("rst_err_clear", sp_err, 1'b0);

        // Pop from all-ones saturates and flags
        sp_pop = 1'b1;
        tick();
        sp_pop = 1'b0;
        readA(2'd2);
        checkOutput("pop_sat_sp", rdata_a, 8'hFF);
        checkOutput("pop_sat_err", sp_err, 1'b1);
        sp_push = 1'b1;
        tick(); tick(); tick();
        sp_push = 1'b0;
        readA(2'd2);
        checkOutput("push3_sp", rdata_a, 8'hFC);
        checkOutput("push3_err_sticky", sp_err, 1'b1);
        sp_pop = 1'b1;
        tick();
        sp_pop = 1'b0;
        readA(2'd2);
        checkOutput("pop_normal_sp", rdata_a, 8'hFD);

        // Push at zero saturates and flags
        doReset();
        we = 1'b1; waddr = 2'd2; wdata = 8'h00;
        tick();
        we = 1'b0; sp_push = 1'b1;
        tick();
        sp_push = 1'b0;
        readA(2'd2);
        checkOutput("push_sat_sp", rdata_a, 8'h00);
        checkOutput("push_sat_err", sp_err, 1'b1);

        // Write to SP collides with push: write wins, no fault
        doReset();
        we = 1'b1; waddr = 2'd2; wdata = 8'h10;
        tick();
        sp_push = 1'b1; wdata = 8'h80;
        tick();
        applyStimulus();
        readA(2'd2);
        checkOutput("collide_sp", rdata_a, 8'h80);
        checkOutput("collide_err", sp_err, 1'b0);
        sp_push = 1'b1; sp_pop = 1'b1;
        tick();
        applyStimulus();
        readA(2'd2);
        checkOutput("push_pop_sp", rdata_a, 8'h80);
        checkOutput("push_pop_err", sp_err, 1'b0);
        sp_push = 1'b1;
        tick();
        sp_push = 1'b0;
        readA(2'd2);
        checkOutput("push_normal_sp", rdata_a, 8'h7F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 DATA_W, 8, register data width in bits, legal range 4..32.
REQ-002 ADDR_W, 2, register address width; NUM_REGS = 2**ADDR_W, legal range 1..5.
REQ-003 SP_IDX, 2, index of the stack-pointer register; SHALL be < NUM_REGS.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 we  input  1  general register write enable.
REQ-007 waddr  input  ADDR_W  write register index.
REQ-008 wdata  input  DATA_W  write data; also the source for temp-register captures.
REQ-009 raddr_a / raddr_b  input  ADDR_W each  read indices for port A (rt) and port B (rs).
REQ-010 rdata_a / rdata_b  output  DATA_W each  read data for port A and port B.
REQ-011 tmp_we  input  1  capture wdata into a compare temp register.
REQ-012 tmp_sel  input  1  temp register select: 0 = t0, 1 = t1.
REQ-013 cmp_mode  input  1  branch-compare mode: port A returns t0, port B returns t1.
REQ-014 sp_push / sp_pop  input  1 each  stack-pointer decrement / increment request.
REQ-015 eq  output  1  registered flag; t0 == t1.
REQ-016 sp_err  output  1  sticky stack overflow/underflow flag.

Function
REQ-017 Reads SHALL be combinational: rdata_a = reg[raddr_a] and rdata_b = reg[raddr_b] when cmp_mode=0; rdata_a = t0 and rdata_b = t1 when cmp_mode=1.
REQ-018 When we=1, reg[waddr] SHALL take wdata at the edge, including wdata = 0, at any index including SP_IDX.
REQ-019 When tmp_we=1, the temp register selected by tmp_sel SHALL take wdata at the edge; tmp_we and we SHALL be independent and may both act in the same cycle.
REQ-020 eq SHALL be registered from the next-state values of t0 and t1, so eq is valid in the cycle after the capture edge (1-cycle latency).
REQ-021 Push SHALL apply reg[SP_IDX] <= reg[SP_IDX] - 1; at SP = 0 the push SHALL leave SP unchanged and set sp_err.
REQ-022 Pop SHALL apply reg[SP_IDX] <= reg[SP_IDX] + 1; at SP = all-ones the pop SHALL leave SP unchanged and set sp_err.
REQ-023 If sp_push and sp_pop are both asserted, SP SHALL be unchanged and sp_err SHALL not be set.
REQ-024 If we=1 with waddr = SP_IDX in the same cycle as a push or pop, the write SHALL win; the push/pop SHALL be dropped and sp_err SHALL not be set.
REQ-025 sp_err SHALL stay at 1 until reset; no other event SHALL clear it.
REQ-026 SP arithmetic SHALL be DATA_W-bit and SHALL never wrap.

Reset
REQ-027 With rst_n=0 at an edge, every register other than SP_IDX SHALL be cleared to 0, reg[SP_IDX] SHALL be set to all-ones, and t0, t1 and sp_err SHALL be cleared to 0.
REQ-028 eq SHALL reset to 1.
REQ-029 While rst_n=0, reset SHALL take priority over we, tmp_we, sp_push and sp_pop.
REQ-030 A write or push/pop in the same cycle as reset SHALL be discarded.
REQ-031 Reads SHALL reflect reset values from the cycle after the reset edge.

Configuration
REQ-032 Macro REGFILE_BYPASS_EN: when defined, a read port whose address equals waddr while we=1 (and cmp_mode=0) SHALL return wdata combinationally in the same cycle.
REQ-033 When REGFILE_BYPASS_EN is undefined, a read port SHALL return the old value until the edge after the write.
REQ-034 The macro SHALL not affect temp registers or the SP push/pop path.

Verification (DATA_W=8, ADDR_W=2)
REQ-035 Reset: rst_n=0 for 1 edge -> reg0=reg1=reg3=0x00, reg2=0xFF, eq=1, sp_err=0.
REQ-036 Write then read: we=1, waddr=1, wdata=0x00 after a prior 0x5A -> next cycle rdata_b=0x00 with raddr_b=1; same-cycle rdata_b = 0x00 with bypass, 0x5A without.
REQ-037 Compare: capture t0=0x40, then t1=0x40 -> eq=1 one cycle later; recapture t1=0x41 -> eq=0; cmp_mode=1 -> rdata_a=0x40, rdata_b=0x41.
REQ-038 Stack pop saturate: from reset, sp_pop=1 for 1 cycle -> SP stays 0xFF, sp_err=1; then 3 pushes -> SP=0xFC, sp_err remains 1.
REQ-039 Push underflow saturate: we=1 waddr=2 wdata=0x00, then sp_push=1 -> SP stays 0x00, sp_err=1.
REQ-040 Collision: SP=0x10, sp_push=1 with we=1 waddr=2 wdata=0x80 -> SP=0x80, sp_err unchanged; push+pop together -> SP unchanged.
